baud_gen_frac: RTL and testbench

//  Parametrised fractional baud-rate generator for the UART datapath (uart2sram).

---
 rtl/baud_gen_frac.sv | 91 +++++++++
 tb/tb_baud_gen_frac.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: the oversample period averages div_int + div_frac/2^FRAC_W
// clocks. It produces oversample and bit ticks and an oversample-rate square wave.
module baud_gen_frac #(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OVERSAMPLE = 16,
    parameter int DEF_INT    = 54,
    parameter int DEF_FRAC   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              resync,
    output logic              tick_os,
    output logic              tick_bit,
    output logic              os_clk
);
    localparam int IDX_W   = $clog2(OVERSAMPLE);
    localparam int LEN_W   = DIV_W + 1;
    localparam int RST_INT = (DEF_INT < 2) ? 2 : DEF_INT;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_HALF = IDX_W'(OVERSAMPLE / 2);

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    logic [DIV_W-1:0]  int_reg;
    logic [FRAC_W-1:0] frac_reg;
    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [IDX_W-1:0]  os_idx;

    logic [FRAC_W:0]   acc_sum;
    logic [LEN_W-1:0]  period_len;
    logic [LEN_W-1:0]  last_cnt;
    logic [LEN_W-1:0]  half_cnt;
    logic              at_last;
    logic              before_half;

    // The carry of the fractional accumulator stretches the current period by one clock.
    assign acc_sum     = {1'b0, acc} + {1'b0, frac_reg};
    assign period_len  = {1'b0, int_reg} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};
    assign last_cnt    = period_len - LEN_W'(1);
    assign half_cnt    = period_len >> 1;
    assign at_last     = ({1'b0, cnt} == last_cnt);
    assign before_half = (({1'b0, cnt} + LEN_W'(1)) == half_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_reg  <= DIV_W'(RST_INT);
            frac_reg <= FRAC_W'(DEF_FRAC);
            cnt      <= '0;
            acc      <= '0;
            os_idx   <= '0;
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
            os_clk   <= 1'b0;
        end else if (load || resync) begin
            if (load) begin
                int_reg  <= clamp_div(div_int);
                frac_reg <= div_frac;
            end
            cnt      <= '0;
            acc      <= '0;
            os_idx   <= resync ? IDX_HALF : '0;
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
            os_clk   <= 1'b0;
        end else if (en) begin
            tick_os  <= at_last;
            tick_bit <= at_last && (os_idx == IDX_LAST);
            if (at_last) begin
                cnt    <= '0;
                acc    <= acc_sum[FRAC_W-1:0];
                os_idx <= (os_idx == IDX_LAST) ? '0 : os_idx + IDX_W'(1);
                os_clk <= 1'b0;
            end else begin
                cnt <= cnt + DIV_W'(1);
                if (before_half)
                    os_clk <= 1'b1;
            end
        end else begin
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
        end
    end
endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: directed scenarios plus random traffic, every cycle compared
// against a closed-form period model (period end n at (n+1)*int + floor((n+1)*frac/2^F)).
module tb_baud_gen_frac;
    localparam int DIV_W      = 16;
    localparam int FRAC_W     = 4;
    localparam int OVERSAMPLE = 16;
    localparam int DEF_INT    = 54;
    localparam int DEF_FRAC   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              load;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              resync;
    logic              tick_os;
    logic              tick_bit;
    logic              os_clk;

    baud_gen_frac #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OVERSAMPLE),
        .DEF_INT(DEF_INT), .DEF_FRAC(DEF_FRAC)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .div_int(div_int),
        .div_frac(div_frac), .resync(resync), .tick_os(tick_os),
        .tick_bit(tick_bit), .os_clk(os_clk)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t_mark   = 0;
    int os_times[$];
    int bit_times[$];
    logic clk_hist[$];

    // Reference model state: divisor, starting bit phase, enabled edges since restart, period index
    longint m_int, m_frac, m_idx0, m_m, m_n;
    logic e_os, e_bit, e_clk;

    function automatic longint pend(input longint n);
        return (n + 1) * m_int + (((n + 1) * m_frac) >> FRAC_W);
    endfunction

    function automatic longint pstart(input longint n);
        return (n == 0) ? 0 : pend(n - 1);
    endfunction

    task automatic model_restart(input longint ni, input longint nf, input longint idx0);
        m_int  = ni;
        m_frac = nf;
        m_idx0 = idx0;
        m_m    = 0;
        m_n    = 0;
        e_os   = 1'b0;
        e_bit  = 1'b0;
        e_clk  = 1'b0;
    endtask

    task automatic model_edge();
        if (load || resync) begin
            model_restart(load ? ((div_int < 2) ? 2 : longint'(div_int)) : m_int,
                          load ? longint'(div_frac) : m_frac,
                          resync ? OVERSAMPLE / 2 : 0);
        end else if (en) begin
            m_m = m_m + 1;
            if (m_m == pend(m_n)) begin
                e_os  = 1'b1;
                e_bit = ((m_idx0 + m_n) % OVERSAMPLE) == OVERSAMPLE - 1;
                m_n   = m_n + 1;
            end else begin
                e_os  = 1'b0;
                e_bit = 1'b0;
            end
            e_clk = (m_m - pstart(m_n)) >= ((pend(m_n) - pstart(m_n)) / 2);
        end else begin
            e_os  = 1'b0;
            e_bit = 1'b0;
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_bit("tick_os", tick_os, e_os);
        check_bit("tick_bit", tick_bit, e_bit);
        check_bit("os_clk", os_clk, e_clk);
        if (tick_os) os_times.push_back(cyc);
        if (tick_bit) bit_times.push_back(cyc);
        clk_hist.push_back(os_clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic mark();
        t_mark = cyc;
        os_times.delete();
        bit_times.delete();
    endtask

    task automatic load_div(input int di, input int df, input logic rs);
        div_int  = DIV_W'(di);
        div_frac = FRAC_W'(df);
        load     = 1'b1;
        resync   = rs;
        step();
        load   = 1'b0;
        resync = 1'b0;
        mark();
    endtask

    function automatic int count_high(input int a, input int b);
        int s = 0;
        for (int c = a; c < b; c++) s += int'(clk_hist[c - 1]);
        return s;
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; resync = 1'b0;
        div_int = '0; div_frac = '0;
        #3;
        check_bit("reset_tick_os", tick_os, 1'b0);
        check_bit("reset_tick_bit", tick_bit, 1'b0);
        check_bit("reset_os_clk", os_clk, 1'b0);
        #9 rst = 1'b0;
        model_restart(DEF_INT, DEF_FRAC, 0);

        // Defaults: 54,54,54,55 spacing, 868 cycles per bit
        en = 1'b1;
        mark();
        run(1800);
        check_int("def_first_os", os_times[0] - t_mark, 54);
        check_int("def_gap1", os_times[1] - os_times[0], 54);
        check_int("def_gap2", os_times[2] - os_times[1], 54);
        check_int("def_gap3", os_times[3] - os_times[2], 55);
        check_int("def_16_os", os_times[16] - os_times[0], 868);
        check_int("def_first_bit", bit_times[0] - t_mark, 868);
        check_int("def_bit_gap", bit_times[1] - bit_times[0], 868);

        // Integer divisor 651
        load_div(651, 0, 1'b0);
        run(10416 + 700);
        check_int("d651_first_os", os_times[0] - t_mark, 651);
        check_int("d651_gap", os_times[2] - os_times[1], 651);
        check_int("d651_high", count_high(os_times[1], os_times[2]), 326);
        check_int("d651_first_bit", bit_times[0] - t_mark, 10416);

        // Divisor 0 clamps to 2
        load_div(0, 0, 1'b0);
        run(40);
        check_int("clamp_first_os", os_times[0] - t_mark, 2);
        check_int("clamp_gap", os_times[5] - os_times[4], 2);
        check_int("clamp_high", count_high(os_times[4], os_times[5]), 1);

        // Enable dropped for 10 cycles inside the first period
        load_div(DEF_INT, DEF_FRAC, 1'b0);
        run(20);
        en = 1'b0;
        run(10);
        en = 1'b1;
        run(200);
        check_int("stall_first_os", os_times[0] - t_mark, 64);
        check_int("stall_gap", os_times[1] - os_times[0], 54);

        // Resync mid-bit: next bit tick after half a bit
        run(int'($urandom_range(100, 700)));
        resync = 1'b1;
        step();
        resync = 1'b0;
        mark();
        run(1320);
        check_int("resync_first_bit", bit_times[0] - t_mark, 434);
        check_int("resync_bit_gap", bit_times[1] - bit_times[0], 868);

        // Asynchronous reset between clock edges
        run(25);
        #2 rst = 1'b1;
        #1;
        check_bit("async_rst_tick_os", tick_os, 1'b0);
        check_bit("async_rst_tick_bit", tick_bit, 1'b0);
        check_bit("async_rst_os_clk", os_clk, 1'b0);
        @(posedge clk);
        cyc++;
        #1;
        clk_hist.push_back(os_clk);
        check_bit("rst_hold_os_clk", os_clk, 1'b0);
        rst = 1'b0;
        model_restart(DEF_INT, DEF_FRAC, 0);
        mark();
        run(60);
        check_int("post_rst_first_os", os_times[0] - t_mark, 54);

        // load and resync together: 8 periods of 10+3/16 = 81 cycles to the first bit tick
        load_div(10, 3, 1'b1);
        run(200);
        check_int("ldrs_first_os", os_times[0] - t_mark, 10);
        check_int("ldrs_first_bit", bit_times[0] - t_mark, 81);

        // Random traffic, including divisor changes without load
        for (int i = 0; i < 4000; i++) begin
            en       = ($urandom_range(0, 7) != 0);
            load     = ($urandom_range(0, 799) == 0);
            resync   = ($urandom_range(0, 499) == 0);
            div_int  = DIV_W'($urandom_range(0, 24));
            div_frac = FRAC_W'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
